// File: rtl/fixed_point_sqrt_pkg.sv
// Shared types and Q-format constants for the fixed-point square-root stage
// that sits downstream of the restoring divider.
package fixed_point_sqrt_pkg;

  // Radicand arrives as the divider's Q10.10 quotient
  localparam int IN_W   = 20;
  localparam int FRAC_W = 10;
  localparam int INT_W  = IN_W - FRAC_W;
  localparam int OUT_W  = (IN_W + FRAC_W) / 2;
  localparam int RAD_W  = IN_W + FRAC_W;

  localparam logic [IN_W-1:0]  Q_IN_ONE  = IN_W'(1) << FRAC_W;
  localparam logic [OUT_W-1:0] Q_OUT_ONE = OUT_W'(1) << FRAC_W;
  localparam logic [OUT_W-1:0] BASE_INIT = OUT_W'(1) << (OUT_W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } sqrt_state_e;

  // Widen the radicand so the integer result carries FRAC_W fractional bits
  function automatic logic [RAD_W-1:0] scale_radicand(input logic [IN_W-1:0] q);
    return {q, {FRAC_W{1'b0}}};
  endfunction

  function automatic logic [RAD_W-1:0] square(input logic [OUT_W-1:0] x);
    logic [RAD_W-1:0] xe;
    xe = RAD_W'(x);
    return xe * xe;
  endfunction

endpackage

// File: rtl/fixed_point_sqrt.sv
// Bit-serial restoring square root: one result bit per clock, MSB first, with
// early exit when a trial squares exactly to the radicand.
module fixed_point_sqrt
  import fixed_point_sqrt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             busy,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_exact
);

  sqrt_state_e      state_q, state_d;
  logic [RAD_W-1:0] rad_q, rad_d;
  logic [OUT_W-1:0] root_q, root_d;
  logic [OUT_W-1:0] base_q, base_d;
  logic             out_valid_d;
  logic [OUT_W-1:0] out_data_d;
  logic             out_exact_d;

  logic [OUT_W-1:0] trial;
  logic [RAD_W-1:0] trial_sq;
  logic             sq_lt;
  logic             sq_eq;
  logic             last_bit;

  // Single combinational squarer and comparator shared by every trial
  assign trial    = root_q | base_q;
  assign trial_sq = square(trial);
  assign sq_lt    = trial_sq < rad_q;
  assign sq_eq    = trial_sq == rad_q;
  assign last_bit = base_q[0];

  assign busy = (state_q == CALC);

  always_comb begin
    state_d     = state_q;
    rad_d       = rad_q;
    root_d      = root_q;
    base_d      = base_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data;
    out_exact_d = out_exact;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          rad_d       = scale_radicand(in_data);
          root_d      = '0;
          base_d      = BASE_INIT;
          out_data_d  = '0;
          out_exact_d = 1'b0;
          state_d     = CALC;
        end
      end

      CALC: begin
        base_d = base_q >> 1;
        if (sq_eq) begin
          // Exact hit: the undecided low bits are genuinely zero
          root_d      = trial;
          out_data_d  = trial;
          out_exact_d = 1'b1;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          if (sq_lt) begin
            root_d = trial;
          end
          if (last_bit) begin
            out_data_d  = sq_lt ? trial : root_q;
            out_exact_d = (rad_q == '0);
            out_valid_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rad_q     <= '0;
      root_q    <= '0;
      base_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_exact <= 1'b0;
    end else begin
      state_q   <= state_d;
      rad_q     <= rad_d;
      root_q    <= root_d;
      base_q    <= base_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_exact <= out_exact_d;
    end
  end

endmodule
